// File: rtl/regbank_write_arbiter_pkg.sv
// Shared definitions for the register-bank write arbiter: bank geometry,
// arbiter state encoding and a small index helper.
package regbank_write_arbiter_pkg;

    localparam int unsigned REG_ADDR_W = 2;
    localparam int unsigned REG_DATA_W = 32;
    localparam int unsigned REG_COUNT  = 4;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Increment an index modulo n (n >= 1).
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return ((v + 1) < n) ? (v + 1) : 0;
    endfunction

endpackage

// File: rtl/regbank_write_arbiter_rr_pick.sv
// Combinational rotate-priority picker: scans req upward from ptr, wrapping
// N-1 -> 0, and returns the first set bit as one-hot, index and any-valid.
module regbank_write_arbiter_rr_pick #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] pos;

    // First requester at or after ptr wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        pos = '0;
        for (int unsigned i = 0; i < N; i++) begin
            pos = IDX_W'((32'(ptr) + i) % N);
            if (!any && req[pos]) begin
                any      = 1'b1;
                idx      = pos;
                gnt[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regbank_write_arbiter.sv
// Round-robin arbiter sharing the register bank's single write port among
// NREQ valid/ready requesters. write/wa/wdata/grant_id are registered, so the
// bank commits one cycle after the handshake.
// Optional grant locking is built when REGBANK_ARB_LOCK_EN is defined.
module regbank_write_arbiter
    import regbank_write_arbiter_pkg::*;
#(
    parameter  int unsigned NREQ     = 4,
    parameter  int unsigned ADDR_W   = REG_ADDR_W,
    parameter  int unsigned DATA_W   = REG_DATA_W,
    parameter  int unsigned LOCK_MAX = 4,
    localparam int unsigned ID_W     = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_data,
    input  logic [NREQ-1:0]        req_lock,
    output logic [NREQ-1:0]        req_ready,
    output logic                   write,
    output logic [ADDR_W-1:0]      wa,
    output logic [DATA_W-1:0]      wdata,
    output logic [ID_W-1:0]        grant_id,
    output logic                   busy
);

    localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

    arb_state_e        state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;

    logic [NREQ-1:0]   owner_mask;
    logic [NREQ-1:0]   pick_req;
    logic [NREQ-1:0]   pick_gnt;
    logic [ID_W-1:0]   pick_idx;
    logic              pick_any;
    logic              hs;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;
    logic [ID_W-1:0]   idx_inc;

    assign owner_mask = NREQ'(1) << owner_q;

    // While locked only the owner is eligible; otherwise everyone is.
    always_comb begin
        pick_req = req_valid;
        if (state_q == ARB_LOCKED) begin
            pick_req = req_valid & owner_mask;
        end
    end

    regbank_write_arbiter_rr_pick #(
        .N     (NREQ),
        .IDX_W (ID_W)
    ) u_pick (
        .req (pick_req),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign req_ready = rst_n ? pick_gnt : '0;
    assign hs        = rst_n & pick_any;
    assign win_addr  = req_addr[32'(pick_idx) * ADDR_W +: ADDR_W];
    assign win_data  = req_data[32'(pick_idx) * DATA_W +: DATA_W];
    assign idx_inc   = ID_W'(wrap_inc(32'(pick_idx), NREQ));

`ifdef REGBANK_ARB_LOCK_EN
    logic             busy_q, busy_d;
    logic [ID_W-1:0]  owner_inc;
    logic             lock_done;

    assign owner_inc = ID_W'(wrap_inc(32'(owner_q), NREQ));
    assign lock_done = (32'(cnt_q) + 1) >= LOCK_MAX;
    assign busy      = busy_q;
`else
    logic unused_lock;

    assign unused_lock = ^req_lock;
    assign busy        = 1'b0;
`endif

    // Next-state: write-port payload, rotating pointer and lock tracking.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        write_d    = hs;
        wa_d       = wa_q;
        wdata_d    = wdata_q;
        grant_id_d = grant_id_q;

        if (hs) begin
            wa_d       = win_addr;
            wdata_d    = win_data;
            grant_id_d = pick_idx;
        end

        case (state_q)
            ARB_IDLE: begin
                if (hs) begin
                    ptr_d = idx_inc;
`ifdef REGBANK_ARB_LOCK_EN
                    if (req_lock[pick_idx] && (LOCK_MAX > 1)) begin
                        state_d = ARB_LOCKED;
                        owner_d = pick_idx;
                        cnt_d   = CNT_W'(1);
                    end
`endif
                end
            end
            ARB_LOCKED: begin
`ifdef REGBANK_ARB_LOCK_EN
                if (!req_valid[owner_q]) begin
                    state_d = ARB_IDLE;
                    ptr_d   = owner_inc;
                    cnt_d   = '0;
                end else if (hs) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (!req_lock[owner_q] || lock_done) begin
                        state_d = ARB_IDLE;
                        ptr_d   = owner_inc;
                        cnt_d   = '0;
                    end
                end
`else
                state_d = ARB_IDLE;
`endif
            end
            default: state_d = ARB_IDLE;
        endcase

`ifdef REGBANK_ARB_LOCK_EN
        busy_d = (state_d == ARB_LOCKED);
`endif
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            cnt_q      <= '0;
            write_q    <= 1'b0;
            wa_q       <= '0;
            wdata_q    <= '0;
            grant_id_q <= '0;
`ifdef REGBANK_ARB_LOCK_EN
            busy_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            write_q    <= write_d;
            wa_q       <= wa_d;
            wdata_q    <= wdata_d;
            grant_id_q <= grant_id_d;
`ifdef REGBANK_ARB_LOCK_EN
            busy_q     <= busy_d;
`endif
        end
    end

    assign write    = write_q;
    assign wa       = wa_q;
    assign wdata    = wdata_q;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Bench for regbank_write_arbiter with a behavioural 4x32 register bank.
module tb_regbank_write_arbiter;

    localparam int unsigned NREQ   = 4;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 32;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_lock;
    logic [NREQ-1:0]        req_ready;
    logic                   write;
    logic [ADDR_W-1:0]      wa;
    logic [DATA_W-1:0]      wdata;
    logic [1:0]             grant_id;
    logic                   busy;

    logic [DATA_W-1:0]      bank [4];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [NREQ-1:0] valid;
        logic [NREQ-1:0] lock;
        logic [NREQ-1:0] ready;
        logic            busy;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    regbank_write_arbiter #(
        .NREQ     (NREQ),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .LOCK_MAX (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_lock  (req_lock),
        .req_ready (req_ready),
        .write     (write),
        .wa        (wa),
        .wdata     (wdata),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    // Register bank: commits on the edge after the arbiter registers a write.
    always @(posedge clk) begin
        if (write) bank[wa] <= wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_default_payload();
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(i);
            req_data[i*DATA_W +: DATA_W] = 32'hC0DE_0000 | 32'(i);
        end
    endtask

    function automatic int onehot_idx(input logic [NREQ-1:0] oh);
        int r = 0;
        for (int i = 0; i < NREQ; i++) if (oh[i]) r = i;
        return r;
    endfunction

    task automatic add(input logic [3:0] v, input logic [3:0] l, input logic [3:0] r, input logic b);
        vec_t e;
        e.valid = v; e.lock = l; e.ready = r; e.busy = b;
        vecs.push_back(e);
    endtask

    initial begin
        int exp_gid;
        int exp_wa;
        logic [31:0] exp_wdata;

        for (int i = 0; i < 4; i++) bank[i] = '0;

        // Fairness from ptr=0 after steering with a lone requester 3.
        add(4'b1000, 4'b0000, 4'b1000, 1'b0);
        for (int k = 0; k < 8; k++) add(4'b1111, 4'b0000, 4'(1 << (k % 4)), 1'b0);
        add(4'b0000, 4'b0000, 4'b0000, 1'b0);
        // Wrap: ptr=3 with 0 and 2 valid -> 0 then 2.
        add(4'b0100, 4'b0000, 4'b0100, 1'b0);
        add(4'b0101, 4'b0000, 4'b0001, 1'b0);
        add(4'b0101, 4'b0000, 4'b0100, 1'b0);
        add(4'b0010, 4'b0000, 4'b0010, 1'b0);
        // Lock: req2 locked, req0 valid, starting at ptr=2.
`ifdef REGBANK_ARB_LOCK_EN
        add(4'b0101, 4'b0100, 4'b0100, 1'b1);
        add(4'b0101, 4'b0100, 4'b0100, 1'b1);
        add(4'b0101, 4'b0100, 4'b0100, 1'b1);
        add(4'b0101, 4'b0100, 4'b0100, 1'b0);
        add(4'b0101, 4'b0100, 4'b0001, 1'b0);
        add(4'b0101, 4'b0100, 4'b0100, 1'b1);
        add(4'b0001, 4'b0000, 4'b0000, 1'b0);
        add(4'b0001, 4'b0000, 4'b0001, 1'b0);
`else
        for (int k = 0; k < 6; k++) add(4'b0101, 4'b0100, (k % 2 == 0) ? 4'b0100 : 4'b0001, 1'b0);
        add(4'b0001, 4'b0000, 4'b0001, 1'b0);
        add(4'b0001, 4'b0000, 4'b0001, 1'b0);
`endif

        // Reset held two cycles with everyone requesting.
        rst_n     = 1'b0;
        req_valid = '1;
        req_lock  = '0;
        set_default_payload();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("reset_ready", 32'(req_ready), 32'h0);
            @(posedge clk); #1;
            chk("reset_write", 32'(write), 32'h0);
            chk("reset_wa", 32'(wa), 32'h0);
            chk("reset_wdata", wdata, 32'h0);
            chk("reset_gid", 32'(grant_id), 32'h0);
            chk("reset_busy", 32'(busy), 32'h0);
        end
        rst_n     = 1'b1;
        req_valid = '0;

        // Single requester 1 writing register 1.
        req_addr[1*ADDR_W +: ADDR_W] = 2'b01;
        req_data[1*DATA_W +: DATA_W] = 32'h0014_5601;
        req_valid = 4'b0010;
        @(negedge clk);
        chk("single_ready", 32'(req_ready), 32'h2);
        @(posedge clk); #1;
        chk("single_write", 32'(write), 32'h1);
        chk("single_wa", 32'(wa), 32'h1);
        chk("single_wdata", wdata, 32'h0014_5601);
        chk("single_gid", 32'(grant_id), 32'h1);
        req_valid = '0;
        @(negedge clk);
        chk("idle_ready", 32'(req_ready), 32'h0);
        @(posedge clk); #1;
        chk("single_bank1", bank[1], 32'h0014_5601);
        chk("idle_write", 32'(write), 32'h0);
        chk("idle_wa_hold", 32'(wa), 32'h1);
        chk("idle_wdata_hold", wdata, 32'h0014_5601);

        // Contention on register 2: req0 then req1 (ptr=2 wraps to 0).
        req_addr[0*ADDR_W +: ADDR_W] = 2'b10;
        req_addr[1*ADDR_W +: ADDR_W] = 2'b10;
        req_data[0*DATA_W +: DATA_W] = 32'h0000_0987;
        req_data[1*DATA_W +: DATA_W] = 32'h0000_AAAA;
        req_valid = 4'b0011;
        @(negedge clk);
        chk("cont_ready0", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        chk("cont_wdata0", wdata, 32'h0000_0987);
        req_valid = 4'b0010;
        @(negedge clk);
        chk("cont_ready1", 32'(req_ready), 32'h2);
        @(posedge clk); #1;
        chk("cont_write1", 32'(write), 32'h1);
        chk("cont_wdata1", wdata, 32'h0000_AAAA);
        req_valid = '0;
        @(posedge clk); #1;
        chk("cont_bank2", bank[2], 32'h0000_AAAA);
        set_default_payload();

        // Table-driven section.
        exp_gid   = 1;
        exp_wa    = 2;
        exp_wdata = 32'h0000_AAAA;
        foreach (vecs[n]) begin
            req_valid = vecs[n].valid;
            req_lock  = vecs[n].lock;
            @(negedge clk);
            if (req_ready !== vecs[n].ready)
                $display("FAIL vec%0d_ready: got %b expected %b", n, req_ready, vecs[n].ready);
            checks++;
            if (req_ready !== vecs[n].ready) errors++;
            @(posedge clk); #1;
            if (vecs[n].ready != '0) begin
                exp_gid   = onehot_idx(vecs[n].ready);
                exp_wa    = exp_gid;
                exp_wdata = 32'hC0DE_0000 | 32'(exp_gid);
            end
            chk($sformatf("vec%0d_write", n), 32'(write), 32'(vecs[n].ready != '0));
            chk($sformatf("vec%0d_wa", n), 32'(wa), 32'(exp_wa));
            chk($sformatf("vec%0d_wdata", n), wdata, exp_wdata);
            chk($sformatf("vec%0d_gid", n), 32'(grant_id), 32'(exp_gid));
            chk($sformatf("vec%0d_busy", n), 32'(busy), 32'(vecs[n].busy));
        end

        req_valid = '0;
        req_lock  = '0;
        @(posedge clk); #1;
        chk("final_write", 32'(write), 32'h0);
        chk("final_bank0", bank[0], 32'hC0DE_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
